// File: rtl/wb_stage_pipe.sv
// MEM/WB slot with writeback mux and load extract/extend; rf_* are driven combinationally from the slot (1 cycle).
// A load waits in the slot until m_ready; wb_stall holds MEM meanwhile, and retire plus accept on one edge gives 1 instr/cycle.
module wb_stage_pipe #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m_valid,
    input  logic [DATA_W-1:0] r_alu,
    input  logic              m2reg,
    input  logic              wreg,
    input  logic [ADDR_W-1:0] rn,
    input  logic [1:0]        ld_size,
    input  logic              ld_unsigned,
    input  logic [DATA_W-1:0] m_o,
    input  logic              m_ready,
    output logic              wb_stall,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] wdi,
    output logic              ld_misalign
);
    localparam int OFF_W = $clog2(DATA_W / 8);

    // WAIT marks an occupied slot holding a load; it only stalls while m_ready is low.
    typedef enum logic [1:0] {EMPTY, FULL, WAIT} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   r_alu_q;
    logic                wreg_q;
    logic [ADDR_W-1:0]   rn_q;
    logic [1:0]          ld_size_q;
    logic                ld_unsigned_q;

    logic                slot_vld, is_load, accept, retire;
    logic [OFF_W-1:0]    off;
    logic [1:0]          sz_eff;
    logic [5:0]          shamt;
    logic                word_hi, sign, mis_raw, misalign, zero_hit;
    logic [DATA_W-1:0]   raw, mask, ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_q       <= '0;
            wreg_q        <= 1'b0;
            rn_q          <= '0;
            ld_size_q     <= 2'b00;
            ld_unsigned_q <= 1'b0;
        end else if (accept) begin
            r_alu_q       <= r_alu;
            wreg_q        <= wreg;
            rn_q          <= rn;
            ld_size_q     <= ld_size;
            ld_unsigned_q <= ld_unsigned;
        end
    end

    always_comb begin
        state_d  = state_q;
        slot_vld = (state_q != EMPTY);
        is_load  = (state_q == WAIT);
        wb_stall = is_load & ~m_ready;
        accept   = m_valid & ~wb_stall;
        retire   = slot_vld & ~wb_stall;
        if (accept) begin
            state_d = m2reg ? WAIT : FULL;
        end else if (retire) begin
            state_d = EMPTY;
        end
    end

    // Lane extraction: shift the addressed lane down to bit 0, then mask and extend.
    always_comb begin
        off     = r_alu_q[OFF_W-1:0];
        sz_eff  = (DATA_W == 32 && ld_size_q == 2'b11) ? 2'b10 : ld_size_q;
        word_hi = (DATA_W == 64) ? off[OFF_W-1] : 1'b0;
        shamt   = 6'd0;
        mis_raw = 1'b0;
        case (sz_eff)
            2'b00: shamt = 6'({off, 3'b000});
            2'b01: begin
                shamt   = 6'({off, 3'b000});
                mis_raw = off[0];
            end
            2'b10: begin
                shamt   = {word_hi, 5'b00000};
                mis_raw = (off[1:0] != 2'b00);
            end
            default: mis_raw = (off != '0);
        endcase
        raw = m_o >> shamt;
        case (sz_eff)
            2'b00:   begin mask = DATA_W'(8'hFF);         sign = raw[7];  end
            2'b01:   begin mask = DATA_W'(16'hFFFF);      sign = raw[15]; end
            2'b10:   begin mask = DATA_W'(32'hFFFF_FFFF); sign = raw[31]; end
            default: begin mask = '1;                     sign = 1'b0;    end
        endcase
        ext = (raw & mask) | ((~ld_unsigned_q & sign) ? ~mask : '0);
    end

    always_comb begin
        misalign    = is_load & mis_raw;
        zero_hit    = (ZERO_REG != 0) && (rn_q == '0);
        rf_we       = retire & wreg_q & ~misalign & ~zero_hit;
        ld_misalign = retire & misalign;
        rf_waddr    = slot_vld ? rn_q : '0;
        wdi         = '0;
        if (rf_we) begin
            wdi = is_load ? ext : r_alu_q;
        end
    end
endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed bench for wb_stage_pipe: a 32-bit and a 64-bit instance share one stimulus stream.
module tb_wb_stage_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        m_valid, m2reg, wreg, ld_unsigned, m_ready;
    logic [1:0]  ld_size;
    logic [4:0]  rn;
    logic [63:0] r_alu, m_o;

    logic        stall32, we32, mis32;
    logic [4:0]  waddr32;
    logic [31:0] wdi32;
    logic        stall64, we64, mis64;
    logic [4:0]  waddr64;
    logic [63:0] wdi64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_stage_pipe #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) u_dut32 (
        .clk(clk), .rst(rst), .m_valid(m_valid), .r_alu(r_alu[31:0]), .m2reg(m2reg),
        .wreg(wreg), .rn(rn), .ld_size(ld_size), .ld_unsigned(ld_unsigned),
        .m_o(m_o[31:0]), .m_ready(m_ready), .wb_stall(stall32), .rf_we(we32),
        .rf_waddr(waddr32), .wdi(wdi32), .ld_misalign(mis32)
    );

    wb_stage_pipe #(.DATA_W(64), .ADDR_W(5), .ZERO_REG(1)) u_dut64 (
        .clk(clk), .rst(rst), .m_valid(m_valid), .r_alu(r_alu), .m2reg(m2reg),
        .wreg(wreg), .rn(rn), .ld_size(ld_size), .ld_unsigned(ld_unsigned),
        .m_o(m_o), .m_ready(m_ready), .wb_stall(stall64), .rf_we(we64),
        .rf_waddr(waddr64), .wdi(wdi64), .ld_misalign(mis64)
    );

    task automatic idle();
        m_valid = 1'b0;
    endtask

    task automatic issue(input logic m2, input logic wr, input logic [4:0] r,
                         input logic [63:0] a, input logic [1:0] sz, input logic u);
        m_valid     = 1'b1;
        m2reg       = m2;
        wreg        = wr;
        rn          = r;
        r_alu       = a;
        ld_size     = sz;
        ld_unsigned = u;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(); m2reg = 0; wreg = 0; rn = 0; r_alu = 0;
        ld_size = 0; ld_unsigned = 0; m_o = 0; m_ready = 0;
        @(negedge clk);
        checks++; if (stall32 !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall32); end
        checks++; if (we32 !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", we32); end
        checks++; if (waddr32 !== 5'd0) begin errors++; $display("FAIL reset_waddr: got %0d expected 0", waddr32); end
        checks++; if (wdi32 !== 32'h0) begin errors++; $display("FAIL reset_wdi: got %h expected 0", wdi32); end
        checks++; if (mis32 !== 1'b0) begin errors++; $display("FAIL reset_mis: got %b expected 0", mis32); end
        checks++; if (we64 !== 1'b0) begin errors++; $display("FAIL reset_we64: got %b expected 0", we64); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_alu();
        issue(0, 1, 5'd3, 64'h1234, 2'b00, 0);
        step(); idle();
        checks++; if (we32 !== 1'b1) begin errors++; $display("FAIL alu_we: got %b expected 1", we32); end
        checks++; if (waddr32 !== 5'd3) begin errors++; $display("FAIL alu_waddr: got %0d expected 3", waddr32); end
        checks++; if (wdi32 !== 32'h1234) begin errors++; $display("FAIL alu_wdi: got %h expected 00001234", wdi32); end
        step();
        checks++; if (we32 !== 1'b0) begin errors++; $display("FAIL alu_retired_we: got %b expected 0", we32); end
        checks++; if (wdi32 !== 32'h0) begin errors++; $display("FAIL alu_retired_wdi: got %h expected 0", wdi32); end
    endtask

    task automatic test_byte_ext();
        m_ready = 1'b1; m_o = 64'h0080_0000;
        issue(1, 1, 5'd5, 64'h2, 2'b00, 0);
        step();
        checks++; if (wdi32 !== 32'hFFFF_FF80) begin errors++; $display("FAIL byte_signed: got %h expected ffffff80", wdi32); end
        checks++; if (we32 !== 1'b1) begin errors++; $display("FAIL byte_we: got %b expected 1", we32); end
        issue(1, 1, 5'd5, 64'h2, 2'b00, 1);
        step(); idle();
        checks++; if (wdi32 !== 32'h0000_0080) begin errors++; $display("FAIL byte_unsigned: got %h expected 00000080", wdi32); end
        m_o = 64'h8001_0000;
        issue(1, 1, 5'd6, 64'h2, 2'b01, 0);
        step(); idle();
        checks++; if (wdi32 !== 32'hFFFF_8001) begin errors++; $display("FAIL half_signed: got %h expected ffff8001", wdi32); end
        m_o = 64'h8000_0001;
        issue(1, 1, 5'd6, 64'h0, 2'b11, 0);
        step(); idle();
        checks++; if (wdi32 !== 32'h8000_0001) begin errors++; $display("FAIL size11_as_word: got %h expected 80000001", wdi32); end
        step();
    endtask

    task automatic test_slow_mem();
        m_ready = 1'b0; m_o = 64'h0;
        issue(1, 1, 5'd7, 64'h0, 2'b10, 0);
        step();
        issue(0, 1, 5'd9, 64'h55, 2'b00, 0);
        for (int i = 0; i < 3; i++) begin
            checks++; if (stall32 !== 1'b1) begin errors++; $display("FAIL slow_stall_%0d: got %b expected 1", i, stall32); end
            checks++; if (we32 !== 1'b0) begin errors++; $display("FAIL slow_we_%0d: got %b expected 0", i, we32); end
            if (i < 2) step();
        end
        m_ready = 1'b1; m_o = 64'hCAFE_BABE;
        #1;
        checks++; if (stall32 !== 1'b0) begin errors++; $display("FAIL slow_release_stall: got %b expected 0", stall32); end
        checks++; if (we32 !== 1'b1) begin errors++; $display("FAIL slow_release_we: got %b expected 1", we32); end
        checks++; if (wdi32 !== 32'hCAFE_BABE) begin errors++; $display("FAIL slow_release_wdi: got %h expected cafebabe", wdi32); end
        checks++; if (waddr32 !== 5'd7) begin errors++; $display("FAIL slow_release_waddr: got %0d expected 7", waddr32); end
        step(); idle();
        checks++; if (waddr32 !== 5'd9) begin errors++; $display("FAIL slow_held_waddr: got %0d expected 9", waddr32); end
        checks++; if (wdi32 !== 32'h55) begin errors++; $display("FAIL slow_held_wdi: got %h expected 00000055", wdi32); end
        step();
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 4; i++) begin
            issue(0, 1, 5'(i), 64'(32'h100 + i), 2'b00, 0);
            step();
            checks++; if (we32 !== 1'b1) begin errors++; $display("FAIL b2b_we_%0d: got %b expected 1", i, we32); end
            checks++; if (waddr32 !== 5'(i)) begin errors++; $display("FAIL b2b_waddr_%0d: got %0d expected %0d", i, waddr32, i); end
            checks++; if (wdi32 !== 32'h100 + i) begin errors++; $display("FAIL b2b_wdi_%0d: got %h expected %h", i, wdi32, 32'h100 + i); end
        end
        idle();
        step();
        checks++; if (we32 !== 1'b0) begin errors++; $display("FAIL b2b_drain_we: got %b expected 0", we32); end
    endtask

    task automatic test_boundaries();
        issue(0, 1, 5'd0, 64'hABC, 2'b00, 0);
        step(); idle();
        checks++; if (we32 !== 1'b0) begin errors++; $display("FAIL zero_reg_we: got %b expected 0", we32); end
        checks++; if (wdi32 !== 32'h0) begin errors++; $display("FAIL zero_reg_wdi: got %h expected 0", wdi32); end
        m_ready = 1'b1; m_o = 64'h1234_5678;
        issue(1, 1, 5'd6, 64'h1, 2'b01, 1);
        step(); idle();
        checks++; if (mis32 !== 1'b1) begin errors++; $display("FAIL misalign_flag: got %b expected 1", mis32); end
        checks++; if (we32 !== 1'b0) begin errors++; $display("FAIL misalign_we: got %b expected 0", we32); end
        step();
        checks++; if (mis32 !== 1'b0) begin errors++; $display("FAIL misalign_pulse: got %b expected 0", mis32); end
    endtask

    task automatic test_reset_in_wait();
        m_ready = 1'b0; m_o = 64'h0;
        issue(1, 1, 5'd8, 64'h0, 2'b10, 0);
        step(); idle();
        checks++; if (stall32 !== 1'b1) begin errors++; $display("FAIL rstwait_pre_stall: got %b expected 1", stall32); end
        rst = 1'b1;
        #1;
        checks++; if (stall32 !== 1'b0) begin errors++; $display("FAIL rstwait_stall: got %b expected 0", stall32); end
        checks++; if (we32 !== 1'b0) begin errors++; $display("FAIL rstwait_we: got %b expected 0", we32); end
        checks++; if (waddr32 !== 5'd0) begin errors++; $display("FAIL rstwait_waddr: got %0d expected 0", waddr32); end
        checks++; if (wdi32 !== 32'h0) begin errors++; $display("FAIL rstwait_wdi: got %h expected 0", wdi32); end
        @(negedge clk);
        rst = 1'b0;
        step();
        m_ready = 1'b1; m_o = 64'hDEAD;
        #1;
        checks++; if (we32 !== 1'b0) begin errors++; $display("FAIL rstwait_late_we: got %b expected 0", we32); end
        step();
        checks++; if (we32 !== 1'b0) begin errors++; $display("FAIL rstwait_late_we2: got %b expected 0", we32); end
    endtask

    task automatic test_wide64();
        m_ready = 1'b1;
        issue(0, 1, 5'd3, 64'h1234_5678_9ABC_DEF0, 2'b00, 0);
        step(); idle();
        checks++; if (we64 !== 1'b1) begin errors++; $display("FAIL w64_alu_we: got %b expected 1", we64); end
        checks++; if (waddr64 !== 5'd3) begin errors++; $display("FAIL w64_alu_waddr: got %0d expected 3", waddr64); end
        checks++; if (wdi64 !== 64'h1234_5678_9ABC_DEF0) begin errors++; $display("FAIL w64_alu_wdi: got %h expected 123456789abcdef0", wdi64); end
        checks++; if (wdi32 !== 32'h9ABC_DEF0) begin errors++; $display("FAIL w32_alu_trunc: got %h expected 9abcdef0", wdi32); end
        m_o = 64'h0080_0000;
        issue(1, 1, 5'd5, 64'h2, 2'b00, 0);
        step(); idle();
        checks++; if (wdi64 !== 64'hFFFF_FFFF_FFFF_FF80) begin errors++; $display("FAIL w64_byte_signed: got %h expected ffffffffffffff80", wdi64); end
        m_o = 64'hCAFE_BABE_0000_0000;
        issue(1, 1, 5'd5, 64'h4, 2'b10, 0);
        step(); idle();
        checks++; if (wdi64 !== 64'hFFFF_FFFF_CAFE_BABE) begin errors++; $display("FAIL w64_word_hi: got %h expected ffffffffcafebabe", wdi64); end
        m_o = 64'h8877_6655_4433_2211;
        issue(1, 1, 5'd5, 64'h8, 2'b11, 0);
        step(); idle();
        checks++; if (wdi64 !== 64'h8877_6655_4433_2211) begin errors++; $display("FAIL w64_full: got %h expected 8877665544332211", wdi64); end
        issue(1, 1, 5'd5, 64'h4, 2'b11, 0);
        step(); idle();
        checks++; if (mis64 !== 1'b1) begin errors++; $display("FAIL w64_full_misalign: got %b expected 1", mis64); end
        checks++; if (we64 !== 1'b0) begin errors++; $display("FAIL w64_full_misalign_we: got %b expected 0", we64); end
        step();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_byte_ext();
        test_slow_mem();
        test_back_to_back();
        test_boundaries();
        test_reset_in_wait();
        test_wide64();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
